gups_top: RTL and testbench

GUPS_TOP -- requirements
Module: gups_top

---
 rtl/gups_pkg.sv | 33 +++
 rtl/gups_lfsr.sv | 41 ++++
 rtl/gups_top.sv | 130 +++++++++++++
 tb/tb_gups_top.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gups_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gups_pkg
//  Description : Shared types and constants for the GUPS update engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package gups_pkg;

    localparam int LFSR_W = 64;

    // Galois right-shift toggle mask for x^64 + x^63 + x^61 + x^60 + 1.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_RD     = 3'd1;
    localparam logic [2:0] ST_RD_GAP = 3'd2;
    localparam logic [2:0] ST_WR     = 3'd3;
    localparam logic [2:0] ST_WR_GAP = 3'd4;

    typedef enum logic [2:0] {
        S_INIT   = ST_INIT,
        S_RD     = ST_RD,
        S_RD_GAP = ST_RD_GAP,
        S_WR     = ST_WR,
        S_WR_GAP = ST_WR_GAP
    } gups_state_e;

    function automatic logic [LFSR_W-1:0] gups_seed_fix(input logic [LFSR_W-1:0] seed);
        return (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gups_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : gups_lfsr
//  Description : 64-bit Galois LFSR with synchronous load and single-step advance.
//  Revision    : 1.0 - initial release
// ============================================================================
module gups_lfsr
    import gups_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic [LFSR_W-1:0] value_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = seed_i;
        end else if (step_i) begin
            lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/gups_top.sv
`default_nettype none
// ============================================================================
//  Module      : gups_top
//  Description : Random read-modify-write (GUPS) engine: read word, write +1.
//                Optional completed-update counter enabled by GUPS_UPDATE_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module gups_top
    import gups_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] addr,
    input  logic [63:0] din,
    output logic [63:0] dout,
    output logic        req,
    output logic        wr,
    input  logic        rdy,
    input  logic [15:0] seed0,
    input  logic [15:0] seed1,
    input  logic [15:0] seed2,
    input  logic [15:0] seed3,
    input  logic [63:0] range
`ifdef GUPS_UPDATE_CNT_EN
    ,
    output logic [63:0] updates
`endif
);

    gups_state_e       state_q;
    gups_state_e       state_d;
    logic [63:0]       addr_q;
    logic [63:0]       addr_d;
    logic [63:0]       dout_q;
    logic [63:0]       dout_d;
    logic              lfsr_load;
    logic              lfsr_step;
    logic [LFSR_W-1:0] lfsr_val;
    logic [LFSR_W-1:0] seed_fix;

    assign seed_fix = gups_seed_fix({seed3, seed2, seed1, seed0});

    gups_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load_i  (lfsr_load),
        .step_i  (lfsr_step),
        .seed_i  (seed_fix),
        .value_o (lfsr_val)
    );

    // The address is latched on RD entry only, so range/seed changes mid-update are invisible.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state_q)
            S_INIT: begin
                lfsr_load = 1'b1;
                addr_d    = seed_fix & range;
                state_d   = S_RD;
            end
            S_RD: begin
                if (rdy) begin
                    dout_d  = din + 64'd1;
                    state_d = S_RD_GAP;
                end
            end
            S_RD_GAP: begin
                state_d = S_WR;
            end
            S_WR: begin
                if (rdy) begin
                    lfsr_step = 1'b1;
                    state_d   = S_WR_GAP;
                end
            end
            S_WR_GAP: begin
                addr_d  = lfsr_val & range;
                state_d = S_RD;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
            addr_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
        end
    end

    assign req  = (state_q == S_RD) || (state_q == S_WR);
    assign wr   = (state_q == S_WR);
    assign addr = addr_q;
    assign dout = dout_q;

`ifdef GUPS_UPDATE_CNT_EN
    logic [63:0] updates_q;
    logic [63:0] updates_d;

    always_comb begin
        updates_d = updates_q;
        if ((state_q == S_WR) && rdy) begin
            updates_d = updates_q + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            updates_q <= '0;
        end else begin
            updates_q <= updates_d;
        end
    end

    assign updates = updates_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gups_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gups_top
//  Description : Directed self-checking bench for gups_top.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gups_top;

    logic        clk;
    logic        rst;
    logic [63:0] addr;
    logic [63:0] din;
    logic [63:0] dout;
    logic        req;
    logic        wr;
    logic        rdy;
    logic [15:0] seed0;
    logic [15:0] seed1;
    logic [15:0] seed2;
    logic [15:0] seed3;
    logic [63:0] rng;
`ifdef GUPS_UPDATE_CNT_EN
    logic [63:0] updates;
`endif

    int checks   = 0;
    int failures = 0;
    int n_writes = 0;

    gups_top dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .req   (req),
        .wr    (wr),
        .rdy   (rdy),
        .seed0 (seed0),
        .seed1 (seed1),
        .seed2 (seed2),
        .seed3 (seed3),
        .range (rng)
`ifdef GUPS_UPDATE_CNT_EN
        ,
        .updates (updates)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_req(input string tag);
        int n = 0;
        while (req !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout: req=%b required 1", tag, req);
        end
    endtask

    task automatic apply_reset(input logic [15:0] s3, input logic [15:0] s2,
                               input logic [15:0] s1, input logic [15:0] s0,
                               input logic [63:0] r);
        @(negedge clk);
        rst = 1'b1;
        rdy = 1'b0;
        seed3 = s3; seed2 = s2; seed1 = s1; seed0 = s0;
        rng = r;
        n_writes = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Full read-then-write update, checking every visible cycle.
    task automatic run_update(input string tag, input logic [63:0] exp_addr,
                              input logic [63:0] rdata, input logic [63:0] exp_dout,
                              input int lr, input int lw);
        wait_req(tag);
        checks++;
        if (wr !== 1'b0 || addr !== exp_addr) begin
            failures++;
            $display("FAIL %s_read: wr=%b addr=%h required wr=0 addr=%h", tag, wr, addr, exp_addr);
        end
        for (int i = 1; i < lr; i++) begin
            @(negedge clk);
            checks++;
            if (req !== 1'b1 || wr !== 1'b0 || addr !== exp_addr) begin
                failures++;
                $display("FAIL %s_rdhold: req=%b wr=%b addr=%h required 1 0 %h", tag, req, wr, addr, exp_addr);
            end
        end
        din = rdata;
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        din = 64'hDEAD_BEEF_0BAD_F00D;
        checks++;
        if (req !== 1'b0 || addr !== exp_addr || dout !== exp_dout) begin
            failures++;
            $display("FAIL %s_rdgap: req=%b addr=%h dout=%h required 0 %h %h", tag, req, addr, dout, exp_addr, exp_dout);
        end
        @(negedge clk);
        for (int i = 0; i < lw; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (req !== 1'b1 || wr !== 1'b1 || addr !== exp_addr || dout !== exp_dout) begin
                failures++;
                $display("FAIL %s_write: req=%b wr=%b addr=%h dout=%h required 1 1 %h %h",
                         tag, req, wr, addr, dout, exp_addr, exp_dout);
            end
        end
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        n_writes++;
        checks++;
        if (req !== 1'b0) begin
            failures++;
            $display("FAIL %s_wrgap: req=%b required 0", tag, req);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b required 0", req); end
        checks++;
        if (wr !== 1'b0) begin failures++; $display("FAIL reset_wr: got %b required 0", wr); end
        checks++;
        if (addr !== 64'h0) begin failures++; $display("FAIL reset_addr: got %h required 0", addr); end
        checks++;
        if (dout !== 64'h0) begin failures++; $display("FAIL reset_dout: got %h required 0", dout); end
`ifdef GUPS_UPDATE_CNT_EN
        checks++;
        if (updates !== 64'h0) begin failures++; $display("FAIL reset_updates: got %0d required 0", updates); end
`endif
        rst = 1'b0;
        #1;
        checks++;
        if (req !== 1'b0) begin failures++; $display("FAIL init_req: got %b required 0", req); end
        @(negedge clk);
        checks++;
        if (req !== 1'b1 || wr !== 1'b0 || addr !== 64'h1) begin
            failures++;
            $display("FAIL first_req: req=%b wr=%b addr=%h required 1 0 1", req, wr, addr);
        end
    endtask

    task automatic test_basic();
        run_update("basic", 64'h1, 64'h5, 64'h6, 3, 3);
        run_update("basic2", 64'h0, 64'h10, 64'h11, 1, 1);
    endtask

    task automatic test_wrap();
        run_update("wrap", 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 2, 1);
    endtask

    task automatic test_zero_seed();
        apply_reset(16'h0, 16'h0, 16'h0, 16'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_update("zs1", 64'h0000_0000_0000_0001, 64'h100, 64'h101, 1, 2);
        run_update("zs2", 64'hD800_0000_0000_0000, 64'h200, 64'h201, 2, 1);
        run_update("zs3", 64'h6C00_0000_0000_0000, 64'h300, 64'h301, 1, 1);
        run_update("zs4", 64'h3600_0000_0000_0000, 64'h400, 64'h401, 4, 2);
    endtask

    task automatic test_sample();
        wait_req("sample");
        rng   = 64'h0F00_0000_0000_0000;
        seed0 = 16'hFFFF;
        run_update("sample", 64'h1B00_0000_0000_0000, 64'h7, 64'h8, 3, 2);
        run_update("sample_next", 64'h0D00_0000_0000_0000, 64'h9, 64'hA, 1, 1);
    endtask

    task automatic test_spurious_rdy();
        wait_req("spur");
        checks++;
        if (wr !== 1'b0 || addr !== 64'h0600_0000_0000_0000) begin
            failures++;
            $display("FAIL spur_read: wr=%b addr=%h required 0 0600000000000000", wr, addr);
        end
        din = 64'h7; rdy = 1'b1;
        @(negedge clk);
        din = 64'h63;
        @(negedge clk);
        rdy = 1'b0;
        checks++;
        if (req !== 1'b1 || wr !== 1'b1 || dout !== 64'h8) begin
            failures++;
            $display("FAIL spur_rdgap: req=%b wr=%b dout=%h required 1 1 8", req, wr, dout);
        end
        rdy = 1'b1;
        @(negedge clk);
        n_writes++;
        @(negedge clk);
        rdy = 1'b0;
        checks++;
        if (req !== 1'b1 || wr !== 1'b0 || addr !== 64'h0300_0000_0000_0000) begin
            failures++;
            $display("FAIL spur_wrgap: req=%b wr=%b addr=%h required 1 0 0300000000000000", req, wr, addr);
        end
        @(negedge clk);
        checks++;
        if (req !== 1'b1 || wr !== 1'b0) begin
            failures++;
            $display("FAIL spur_hold: req=%b wr=%b required 1 0", req, wr);
        end
`ifdef GUPS_UPDATE_CNT_EN
        checks++;
        if (updates !== 64'(n_writes)) begin
            failures++;
            $display("FAIL spur_updates: got %0d required %0d", updates, n_writes);
        end
`endif
    endtask

    task automatic test_reset_mid_write();
        wait_req("midrst");
        din = 64'h1; rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (req !== 1'b1 || wr !== 1'b1) begin
            failures++;
            $display("FAIL midrst_inwr: req=%b wr=%b required 1 1", req, wr);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (req !== 1'b0 || wr !== 1'b0 || addr !== 64'h0 || dout !== 64'h0) begin
            failures++;
            $display("FAIL midrst_async: req=%b wr=%b addr=%h dout=%h required 0 0 0 0", req, wr, addr, dout);
        end
        seed3 = 16'h0; seed2 = 16'h0; seed1 = 16'h0; seed0 = 16'hABCD;
        rng = 64'hFF;
        n_writes = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req !== 1'b0) begin failures++; $display("FAIL midrst_init: req=%b required 0", req); end
        @(negedge clk);
        checks++;
        if (req !== 1'b1 || wr !== 1'b0 || addr !== 64'hCD) begin
            failures++;
            $display("FAIL midrst_next: req=%b wr=%b addr=%h required 1 0 cd", req, wr, addr);
        end
`ifdef GUPS_UPDATE_CNT_EN
        checks++;
        if (updates !== 64'h0) begin failures++; $display("FAIL midrst_updates: got %0d required 0", updates); end
`endif
    endtask

    task automatic test_random_model();
        logic [63:0] mem [8];
        logic [63:0] a_full;
        logic [7:0]  touched;
        int          lat;
        for (int i = 0; i < 8; i++) mem[i] = 64'(i) * 64'h0101_0101_0101_0101;
        mem[7] = 64'hFFFF_FFFF_FFFF_FFFF;
        touched = '0;
        apply_reset(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF1, 64'h7);
        for (int u = 0; u < 300; u++) begin
            wait_req("rnd_rd");
            checks++;
            if (wr !== 1'b0 || (addr & ~rng) !== 64'h0) begin
                failures++;
                $display("FAIL rnd_read: wr=%b addr=%h required wr=0 addr within %h", wr, addr, rng);
            end
            a_full = addr;
            touched[a_full[2:0]] = 1'b1;
            lat = $urandom_range(1, 4);
            repeat (lat - 1) @(negedge clk);
            din = mem[a_full[2:0]];
            rdy = 1'b1;
            @(negedge clk);
            rdy = 1'b0;
            wait_req("rnd_wr");
            checks++;
            if (wr !== 1'b1 || addr !== a_full || dout !== mem[a_full[2:0]] + 64'd1) begin
                failures++;
                $display("FAIL rnd_write: wr=%b addr=%h dout=%h required 1 %h %h",
                         wr, addr, dout, a_full, mem[a_full[2:0]] + 64'd1);
            end
            mem[a_full[2:0]] = mem[a_full[2:0]] + 64'd1;
            lat = $urandom_range(1, 4);
            repeat (lat - 1) @(negedge clk);
            rdy = 1'b1;
            @(negedge clk);
            rdy = 1'b0;
            n_writes++;
        end
        checks++;
        if ($countones(touched) < 2) begin
            failures++;
            $display("FAIL rnd_spread: touched=%b required at least two addresses", touched);
        end
`ifdef GUPS_UPDATE_CNT_EN
        checks++;
        if (updates !== 64'(n_writes)) begin
            failures++;
            $display("FAIL rnd_updates: got %0d required %0d", updates, n_writes);
        end
`endif
    endtask

    initial begin
        rst   = 1'b1;
        rdy   = 1'b0;
        din   = 64'h0;
        seed0 = 16'h1; seed1 = 16'h0; seed2 = 16'h0; seed3 = 16'h0;
        rng   = 64'h1FFF;
        test_reset();
        test_basic();
        test_wrap();
        test_zero_seed();
        test_sample();
        test_spurious_rdy();
        test_reset_mid_write();
        test_random_model();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
